// File: rtl/nios2_ram_burst.sv
// Burst-capable single-port RAM slave with Avalon-MM style handshake,
// optional zero-fill after reset, byte lanes, write protect and clock enable.
module nios2_ram_burst #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int DEPTH          = 2**ADDR_W,
  parameter int READ_LATENCY   = 1,
  parameter int MAX_BURST      = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_W-1:0]              address,
  input  logic [DATA_W/8-1:0]            byteenable,
  input  logic                           chipselect,
  input  logic                           read,
  input  logic                           write,
  input  logic [DATA_W-1:0]              writedata,
  input  logic [$clog2(MAX_BURST):0]     burstcount,
  input  logic                           clken,
  input  logic                           freeze,
  output logic [DATA_W-1:0]              readdata,
  output logic                           readdatavalid,
  output logic                           waitrequest
);
  localparam int BE_W = DATA_W / 8;
  localparam int BC_W = $clog2(MAX_BURST) + 1;
  localparam int MA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a command transfers on a rising edge where chipselect, clken and
  // read or write are high while waitrequest is low; each readdatavalid cycle
  // (only ever high with clken) delivers exactly one beat on readdata.

  typedef enum logic [1:0] {CLEAR, IDLE, RBURST, WBURST} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [BC_W-1:0]   cnt_q, cnt_n;
  logic [BC_W-1:0]   beats;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [BE_W-1:0]   w_be;
  logic              rd_issue;
  logic [ADDR_W-1:0] rd_addr;

  logic [DATA_W-1:0]       rd_d [READ_LATENCY];
  logic [READ_LATENCY-1:0] rd_v;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (32'(a) >= DEPTH - 1) ? '0 : a + ADDR_W'(1);
  endfunction

  always_comb begin
    beats = burstcount;
    if (burstcount == '0)
      beats = BC_W'(1);
    else if (32'(burstcount) > MAX_BURST)
      beats = BC_W'(MAX_BURST);
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    cnt_n       = cnt_q;
    we          = 1'b0;
    w_addr      = addr_q;
    w_data      = writedata;
    w_be        = byteenable;
    rd_issue    = 1'b0;
    rd_addr     = addr_q;
    waitrequest = 1'b1;
    if (reset_n && clken) begin
      case (state)
        CLEAR: begin
          we     = 1'b1;
          w_data = '0;
          w_be   = '1;
          addr_n = next_addr(addr_q);
          if (32'(addr_q) >= DEPTH - 1)
            state_n = IDLE;
        end
        IDLE: begin
          waitrequest = 1'b0;
          if (chipselect && (read || write)) begin
            addr_n = next_addr(address);
            cnt_n  = beats - BC_W'(1);
            if (write) begin
              we     = !freeze;
              w_addr = address;
              if (beats != BC_W'(1)) state_n = WBURST;
            end else begin
              rd_issue = 1'b1;
              rd_addr  = address;
              if (beats != BC_W'(1)) state_n = RBURST;
            end
          end
        end
        RBURST: begin
          rd_issue = 1'b1;
          addr_n   = next_addr(addr_q);
          cnt_n    = cnt_q - BC_W'(1);
          if (cnt_q == BC_W'(1)) state_n = IDLE;
        end
        WBURST: begin
          waitrequest = 1'b0;
          if (write) begin
            we     = !freeze;
            addr_n = next_addr(addr_q);
            cnt_n  = cnt_q - BC_W'(1);
            if (cnt_q == BC_W'(1)) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      cnt_q  <= cnt_n;
    end
  end

  // Memory has no reset so its contents survive a reset unless CLEAR runs.
  always_ff @(posedge clk) begin
    if (we && in_range(w_addr)) begin
      for (int i = 0; i < BE_W; i++)
        if (w_be[i]) mem[w_addr[MA_W-1:0]][i*8 +: 8] <= w_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_d[i] <= '0;
    end else if (clken) begin
      rd_v[0] <= rd_issue;
      if (rd_issue) rd_d[0] <= in_range(rd_addr) ? mem[rd_addr[MA_W-1:0]] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
    end
  end

  assign readdata      = rd_d[READ_LATENCY-1];
  assign readdatavalid = rd_v[READ_LATENCY-1] & clken;

endmodule

// File: doc/nios2_ram_burst.md
NIOS2_RAM_BURST -- requirements
Module: nios2_ram_burst

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width in bits (16, 32 or 64).
REQ-002 The block SHALL have parameter ADDR_W, default 14, word-address width.
REQ-003 The block SHALL have parameter DEPTH, default 2**ADDR_W, number of words (at most 2**ADDR_W).
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, cycles from read issue to readdatavalid (1 or 2).
REQ-005 The block SHALL have parameter MAX_BURST, default 8, largest legal burstcount (a power of 2).
REQ-006 The block SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill memory after reset when 1.
REQ-007 The block SHALL have ports:
clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
address  in  ADDR_W  word address, first beat
byteenable  in  DATA_W/8  write lane enables
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request or write beat
writedata  in  DATA_W  write data
burstcount  in  clog2(MAX_BURST)+1  beats in burst
clken  in  1  global clock enable
freeze  in  1  write protect
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata qualifier
waitrequest  out  1  command stall

Function
REQ-008 The FSM SHALL have states CLEAR, IDLE, RBURST and WBURST.
REQ-009 Memory SHALL be an internal DEPTH x DATA_W array with byte-lane write enables.
REQ-010 On reset release, the FSM SHALL enter CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-011 CLEAR SHALL write zero to words 0..DEPTH-1, one per enabled cycle, hold waitrequest=1, then go to IDLE after word DEPTH-1.
REQ-012 In IDLE, waitrequest SHALL be 0, and a command SHALL be accepted on any cycle with chipselect=1, clken=1 and read or write asserted.
REQ-013 When read and write are both asserted, write SHALL take priority and the read SHALL be ignored.
REQ-014 A burstcount of 0 SHALL be treated as 1, and a burstcount above MAX_BURST SHALL be treated as MAX_BURST.
REQ-015 On an accepted read of N beats, the block SHALL issue internal reads to addresses A..A+N-1, one per enabled cycle, starting in the accept cycle.
REQ-016 For a read burst with N>1, the FSM SHALL stay in RBURST with waitrequest=1 until the last internal read issues, then return to IDLE.
REQ-017 Each internal read SHALL produce exactly one readdatavalid pulse, with its data on readdata, READ_LATENCY enabled cycles later.
REQ-018 An accepted write SHALL store beat 1 at address A in the accept cycle, then go to WBURST when N>1.
REQ-019 In WBURST, waitrequest SHALL be 0, each cycle with write=1 SHALL store the next beat at the incrementing address, address input SHALL be ignored, and the FSM SHALL return to IDLE after beat N.
REQ-020 Burst address increments SHALL wrap from DEPTH-1 to 0.
REQ-021 A single-beat first address of DEPTH or more SHALL read as 0 and write as no-op.
REQ-022 Only lanes with byteenable=1 SHALL be modified, and an all-zero byteenable beat SHALL be consumed without changing memory.
REQ-023 While freeze=1, write beats SHALL be accepted and counted but SHALL NOT modify memory; reads SHALL be unaffected, and CLEAR SHALL ignore freeze.
REQ-024 While clken=0, all state, counters and the read pipeline SHALL hold, waitrequest SHALL be 1 and readdatavalid SHALL be 0, and held data SHALL be delivered after clken returns to 1.
REQ-025 A read issued the cycle after a write to the same address SHALL return the new data.

Reset
REQ-026 While reset_n=0, outputs SHALL be readdata=0, readdatavalid=0 and waitrequest=1, the FSM SHALL be in CLEAR or IDLE per REQ-010, and burst counters SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst and drop pending readdatavalid pulses; memory content SHALL be retained unless CLEAR runs.

Verification
REQ-028 With CLEAR_ON_RESET=1 and DEPTH=16: release reset -> waitrequest=1 for exactly 16 cycles, then every address reads 0.
REQ-029 With DATA_W=32 and READ_LATENCY=2: write 0x11223344 to address 5 with byteenable=4'b0101, after prior content 0xFFFFFFFF, then read address 5 -> readdatavalid exactly 2 cycles after accept, readdata=0xFF22FF44.
REQ-030 With DEPTH=16: write burst at address 14, burstcount 4, data 1,2,3,4, then read burst at 14, burstcount 4 -> addresses 14,15,0,1 return 1,2,3,4 in four consecutive readdatavalid cycles, and waitrequest=1 for 3 cycles after accept.
REQ-031 Set freeze=1 and write 0xA5 to address 3 -> command accepted, and a later read of address 3 returns the old value.
REQ-032 Hold clken low for 3 cycles mid read burst -> readdatavalid stays 0, and the burst resumes with no beats lost or duplicated.
REQ-033 Assert reset_n low during beat 2 of an 8-beat read -> readdatavalid=0 immediately, and after release the block re-enters CLEAR or IDLE per REQ-010 with no stray data beats.
